// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, one bit per clock,
// with optional repeats separated by idle gaps and a start/busy/done handshake.
module seq_pattern_tx #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             seq_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_out
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSend   = 2'd1,
        StGap    = 2'd2,
        StFinish = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   top_q, top_d;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic               seq_q, seq_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [IDX_W-1:0]   top_in;

    assign len_clamp = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign top_in    = IDX_W'(len_clamp - 1'b1);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        top_d   = top_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        seq_d   = 1'b0;
        valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                // abort has priority over a simultaneous start
                if (start && !abort && (pat_len != '0)) begin
                    state_d = StSend;
                    pat_d   = pattern;
                    top_d   = top_in;
                    bit_d   = top_in;
                    rep_d   = repeat_cnt;
                    gap_d   = gap_len;
                    seq_d   = pattern[top_in];
                    valid_d = 1'b1;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_q == '0) begin
                    if (rep_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        bit_d = top_q;
                        if (gap_q != '0) begin
                            state_d = StGap;
                            gcnt_d  = gap_q;
                        end else begin
                            seq_d   = pat_q[top_q];
                            valid_d = 1'b1;
                        end
                    end
                end else begin
                    bit_d   = bit_q - 1'b1;
                    seq_d   = pat_q[bit_q - 1'b1];
                    valid_d = 1'b1;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gcnt_q == GAP_W'(1)) begin
                    state_d = StSend;
                    seq_d   = pat_q[bit_q];
                    valid_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StSend) || (state_d == StGap);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pat_q   <= '0;
            top_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            seq_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            top_q   <= top_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign seq_out   = seq_q;
    assign bit_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = state_q;

endmodule
